// File: rtl/conv_mac.sv
// Serial convolution MAC: bias plus KERNEL_TAPS signed pixel*weight products, one tap per cycle.
// Define CONV_MAC_SAT_EN to saturate the result to the output range; otherwise it wraps.
`ifndef Pixel_DataSize
`define Pixel_DataSize 8
`endif

module conv_mac #(
  parameter int unsigned KERNEL_TAPS = 9,
  parameter int unsigned ACC_W       = `Pixel_DataSize*2+5
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [`Pixel_DataSize-1:0]      pixel,
  input  logic signed [`Pixel_DataSize-1:0]      weight,
  input  logic signed [`Pixel_DataSize*2:0]      bias,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [`Pixel_DataSize*2:0]      out
);

  localparam int unsigned PIX_W  = `Pixel_DataSize;
  localparam int unsigned PROD_W = 2*PIX_W;
  localparam int unsigned OUT_W  = 2*PIX_W+1;
  localparam int unsigned CNT_W  = $clog2(KERNEL_TAPS+1);

`ifdef CONV_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                   state, state_next;
  logic signed [ACC_W-1:0]  acc, acc_next, base, sum;
  logic [CNT_W-1:0]         cnt, cnt_next, cnt_inc;
  logic signed [OUT_W-1:0]  out_next;
  logic                     out_valid_next;
  logic                     accept, first;
  logic signed [PROD_W-1:0] prod;

  // Reduce the accumulator to the output width (saturate or wrap).
  function automatic logic signed [OUT_W-1:0] fmt(input logic signed [ACC_W-1:0] v);
`ifdef CONV_MAC_SAT_EN
    if (v > SAT_MAX)      fmt = SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) fmt = SAT_MIN[OUT_W-1:0];
    else                  fmt = v[OUT_W-1:0];
`else
    fmt = v[OUT_W-1:0];
`endif
  endfunction

  assign prod = PROD_W'(pixel) * PROD_W'(weight);

  // Next-state, datapath and handshake; a first tap restarts the sum from bias.
  always_comb begin
    state_next     = state;
    acc_next       = acc;
    cnt_next       = cnt;
    out_next       = out;
    out_valid_next = out_valid;
    in_ready       = 1'b0;
    first          = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        first    = 1'b1;
      end
      ACC: in_ready = 1'b1;
      HOLD: begin
        in_ready = out_ready;
        first    = 1'b1;
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (reset) in_ready = 1'b0;

    accept  = in_valid && in_ready;
    base    = first ? ACC_W'(bias) : acc;
    sum     = base + ACC_W'(prod);
    cnt_inc = cnt + CNT_W'(1);

    if (accept) begin
      acc_next = sum;
      if (first) begin
        cnt_next   = CNT_W'(1);
        state_next = ACC;
      end else if (cnt_inc == CNT_W'(KERNEL_TAPS)) begin
        out_next       = fmt(sum);
        out_valid_next = 1'b1;
        cnt_next       = '0;
        state_next     = HOLD;
      end else begin
        cnt_next = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      out       <= out_next;
      out_valid <= out_valid_next;
    end
  end

endmodule

// File: tb/tb_conv_mac.sv
// Self-checking bench for conv_mac: directed test-plan kernels plus randomized traffic
// checked every cycle against a sum-of-products reference model.
`ifndef Pixel_DataSize
`define Pixel_DataSize 8
`endif

module tb_conv_mac;

  localparam int PW    = `Pixel_DataSize;
  localparam int OUT_W = 2*PW+1;
  localparam int TAPS  = 9;

`ifdef CONV_MAC_SAT_EN
  localparam longint EXP_NEG = -65536;
  localparam longint EXP_POS = 65535;
`else
  localparam longint EXP_NEG = -15332;
  localparam longint EXP_POS = 14089;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [PW-1:0]    pixel;
  logic signed [PW-1:0]    weight;
  logic signed [OUT_W-1:0] bias;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out;

  always #5 clk = ~clk;

  conv_mac #(.KERNEL_TAPS(TAPS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .pixel(pixel), .weight(weight), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc   = 0;
  bit     rnd_ready = 1'b0;

  // Reference model: taps collected so far, running sum, result waiting downstream.
  int     m_n     = 0;
  longint m_sum   = 0;
  bit     m_valid = 1'b0;
  longint m_out   = 0;

  function automatic longint ref_fmt(input longint s);
    longint lim;
    longint w;
    lim = longint'(1) << (2*PW);
`ifdef CONV_MAC_SAT_EN
    w = s;
    if (s > lim - 1) w = lim - 1;
    if (s < -lim)    w = -lim;
`else
    w = s & ((longint'(1) << OUT_W) - 1);
    if (w >= lim) w = w - 2*lim;
`endif
    return w;
  endfunction

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic cycle(output bit taken);
    bit exp_rdy;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    exp_rdy = !(m_valid && !out_ready);
    check_eq("in_ready", longint'(in_ready), longint'(exp_rdy));
    taken = in_valid && exp_rdy;
    if (m_valid && out_ready) m_valid = 1'b0;
    if (taken) begin
      if (m_n == 0) m_sum = longint'(bias);
      m_sum = m_sum + longint'(pixel) * longint'(weight);
      m_n++;
      if (m_n == TAPS) begin
        m_valid = 1'b1;
        m_out   = ref_fmt(m_sum);
        m_n     = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("out_valid", longint'(out_valid), longint'(m_valid));
    if (m_valid) check_eq("out", longint'(out), m_out);
  endtask

  task automatic send_tap(input int p, input int w, input int b, output int waits);
    bit taken;
    pixel    = PW'(p);
    weight   = PW'(w);
    bias     = OUT_W'(b);
    in_valid = 1'b1;
    taken    = 1'b0;
    waits    = 0;
    while (!taken && waits < 64) begin
      cycle(taken);
      if (!taken) waits++;
    end
    check_eq("tap_accept", longint'(taken), 1);
  endtask

  task automatic idle(input int n);
    bit taken;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      pixel  = PW'($urandom);
      weight = PW'($urandom);
      bias   = OUT_W'($urandom);
      cycle(taken);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wt;
    int start;
    int b;
    bit taken;

    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    pixel = '0; weight = '0; bias = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_out", longint'(out), 0);
    check_eq("rst_in_ready", longint'(in_ready), 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    out_ready = 1'b1;

    for (int i = 1; i <= TAPS; i++) send_tap(i, 1, 0, wt);
    check_eq("basic", longint'(out), 45);
    idle(2);

    for (int i = 0; i < TAPS; i++) send_tap(-128, 127, -100, wt);
    check_eq("neg_sat", longint'(out), EXP_NEG);
    idle(2);

    for (int i = 0; i < TAPS; i++) send_tap(127, 127, 0, wt);
    check_eq("pos_sat", longint'(out), EXP_POS);
    idle(2);

    // Backpressure then back-to-back kernel.
    out_ready = 1'b0;
    for (int i = 0; i < TAPS; i++) send_tap(1, 1, 0, wt);
    pixel = PW'(2); weight = PW'(3); bias = OUT_W'(10); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(taken);
      check_eq("bp_taken", longint'(taken), 0);
      check_eq("bp_out", longint'(out), 9);
    end
    out_ready = 1'b1;
    start = cyc;
    send_tap(2, 3, 10, wt);
    check_eq("b2b_first_wait", wt, 0);
    for (int i = 1; i < TAPS; i++) send_tap(2, 3, 10, wt);
    check_eq("b2b_latency", cyc - start, 9);
    check_eq("b2b", longint'(out), 64);
    idle(2);

    for (int i = 1; i <= TAPS; i++) begin
      send_tap(i, -1, 5, wt);
      if (i < TAPS) idle(1);
    end
    check_eq("gaps", longint'(out), -40);
    idle(2);

    // Asynchronous reset mid-kernel.
    for (int i = 0; i < 4; i++) send_tap(2, 2, 1, wt);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", longint'(out_valid), 0);
    check_eq("mid_rst_out", longint'(out), 0);
    check_eq("mid_rst_in_ready", longint'(in_ready), 0);
    m_n = 0; m_sum = 0; m_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < TAPS; i++) send_tap(2, 2, 1, wt);
    check_eq("post_rst", longint'(out), 37);
    idle(2);

    // Random traffic with random gaps, garbage bias on later taps and random backpressure.
    rnd_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      b = int'($urandom_range(0, 131071)) - 65536;
      for (int t = 0; t < TAPS; t++) begin
        send_tap(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 (t == 0) ? b : int'($urandom_range(0, 131071)) - 65536, wt);
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
